ram_arbiter: RTL



---
 rtl/ram_arbiter_if.sv | 40 ++++
 rtl/ram_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// Two-port request/grant bus between the CPU data port (m0), the loader port (m1)
// and the shared RAM arbiter.
interface ram_arbiter_if #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned STRB_W = DATA_W / 8;

   logic              m0_req;
   logic              m0_we;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic [STRB_W-1:0] m0_wstrb;
   logic              m0_gnt;
   logic              m0_rvalid;
   logic [DATA_W-1:0] m0_rdata;

   logic              m1_req;
   logic              m1_we;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic [STRB_W-1:0] m1_wstrb;
   logic              m1_gnt;
   logic              m1_rvalid;
   logic [DATA_W-1:0] m1_rdata;

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
      input  m0_gnt, m0_rvalid, m0_rdata,
      output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
      input  m1_gnt, m1_rvalid, m1_rdata
   );

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
      output m0_gnt, m0_rvalid, m0_rdata,
      input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
      output m1_gnt, m1_rvalid, m1_rdata
   );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin two-port arbiter in front of a single-port byte-writable RAM.
// Grants are combinational; read data returns one cycle after the accept edge.
module ram_arbiter #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 32
) (
   input logic         clk,
   input logic         resetn,
   ram_arbiter_if.slave bus
);
   localparam int unsigned DEPTH  = 2 ** ADDR_W;
   localparam int unsigned STRB_W = DATA_W / 8;

   typedef enum logic {
      LAST_M0 = 1'b0,
      LAST_M1 = 1'b1
   } last_e;

   last_e             last_q, last_d;
   logic              gnt0_c, gnt1_c;
   logic              acc_c, acc_we_c;
   logic [ADDR_W-1:0] acc_addr_c;
   logic [DATA_W-1:0] acc_wdata_c;
   logic [STRB_W-1:0] acc_wstrb_c;
   logic [DATA_W-1:0] rd_word_c;

   logic              rvalid0_q, rvalid0_d;
   logic              rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Arbitration: a lone requester always wins; on a tie the port that lost last time wins.
   always_comb begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
      last_d = last_q;
      if (resetn) begin
         if (bus.m0_req && (!bus.m1_req || (last_q == LAST_M1))) begin
            gnt0_c = 1'b1;
         end else if (bus.m1_req) begin
            gnt1_c = 1'b1;
         end
      end
      if (gnt0_c) begin
         last_d = LAST_M0;
      end else if (gnt1_c) begin
         last_d = LAST_M1;
      end
   end

   always_comb begin
      acc_c       = gnt0_c | gnt1_c;
      acc_we_c    = gnt1_c ? bus.m1_we    : bus.m0_we;
      acc_addr_c  = gnt1_c ? bus.m1_addr  : bus.m0_addr;
      acc_wdata_c = gnt1_c ? bus.m1_wdata : bus.m0_wdata;
      acc_wstrb_c = gnt1_c ? bus.m1_wstrb : bus.m0_wstrb;
      rd_word_c   = mem_q[acc_addr_c];
   end

   // RAM array is deliberately not reset.
   always_ff @(posedge clk) begin
      if (acc_c && acc_we_c) begin
         for (int b = 0; b < int'(STRB_W); b++) begin
            if (acc_wstrb_c[b]) begin
               mem_q[acc_addr_c][8*b +: 8] <= acc_wdata_c[8*b +: 8];
            end
         end
      end
   end

   // Each port's read data holds until that port's next read completes.
   always_comb begin
      rvalid0_d = gnt0_c & ~bus.m0_we;
      rvalid1_d = gnt1_c & ~bus.m1_we;
      rdata0_d  = rvalid0_d ? rd_word_c : rdata0_q;
      rdata1_d  = rvalid1_d ? rd_word_c : rdata1_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_q    <= LAST_M1;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         last_q    <= last_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

   assign bus.m0_gnt    = gnt0_c;
   assign bus.m1_gnt    = gnt1_c;
   assign bus.m0_rvalid = rvalid0_q;
   assign bus.m1_rvalid = rvalid1_q;
   assign bus.m0_rdata  = rdata0_q;
   assign bus.m1_rdata  = rdata1_q;
endmodule
